div_radix2_stall: RTL

//  Multi-cycle 32-bit signed/unsigned radix-2 restoring divider for the MIPS EX stage (DIV/DIVU).

---
 rtl/div_radix2_stall_if.sv | 23 ++
 rtl/div_radix2_stall.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div_radix2_stall_if.sv
// div_radix2_stall_if: request/result bundle between the EX stage and the radix-2 divider.
// master issues operands and flushes; slave returns stall, the ready pulse and HI/LO.
interface div_radix2_stall_if #(parameter int W = 32);
   logic         start_i;
   logic         signed_i;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         annul_i;
   logic         stall_o;
   logic         ready_o;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;

   modport master (
      output start_i, signed_i, a_i, b_i, annul_i,
      input  stall_o, ready_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, signed_i, a_i, b_i, annul_i,
      output stall_o, ready_o, hi_o, lo_o
   );
endinterface

// File: rtl/div_radix2_stall.sv
// div_radix2_stall: W-bit signed/unsigned restoring divider, result W+1 cycles after start; stall_o holds the pipeline.
// DIV_ZERO_FAST_EN: when defined, a zero divisor finishes in 2 cycles via the ZERO state.
module div_radix2_stall #(
   parameter int W = 32
) (
   input logic               clk,
   input logic               rst,
   div_radix2_stall_if.slave bus
);
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
`ifdef DIV_ZERO_FAST_EN
      DONE = 2'd2,
      ZERO = 2'd3
`else
      DONE = 2'd2
`endif
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  rem;
   logic [W-1:0]  quo;
   logic [W-1:0]  dvs;
   logic [W-1:0]  raw_a;
   logic          q_neg;
   logic          r_neg;
   logic          dz;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          ready;

   logic [W-1:0]  a_abs;
   logic [W-1:0]  b_abs;
   logic [W:0]    part;
   logic [W:0]    diff;
   logic          ge;
   logic [W-1:0]  nrem;
   logic [W-1:0]  nquo;
   logic [W-1:0]  res_hi;
   logic [W-1:0]  res_lo;

   always_comb begin
      a_abs = (bus.signed_i && bus.a_i[W-1]) ? -bus.a_i : bus.a_i;
      b_abs = (bus.signed_i && bus.b_i[W-1]) ? -bus.b_i : bus.b_i;
      part  = {rem, quo[W-1]};
      diff  = part - {1'b0, dvs};
      // A set top bit means part >= 2^W > divisor, so the subtraction always succeeds.
      ge    = part[W] | ~diff[W];
      nrem  = ge ? diff[W-1:0] : part[W-1:0];
      nquo  = {quo[W-2:0], ge};
      if (dz) begin
         res_lo = '1;
         res_hi = raw_a;
      end else begin
         res_lo = q_neg ? -nquo : nquo;
         res_hi = r_neg ? -nrem : nrem;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         raw_a <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         dz    <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         ready <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i && !bus.annul_i) begin
                  rem   <= '0;
                  quo   <= a_abs;
                  dvs   <= b_abs;
                  raw_a <= bus.a_i;
                  q_neg <= (bus.a_i[W-1] ^ bus.b_i[W-1]) & bus.signed_i;
                  r_neg <= bus.a_i[W-1] & bus.signed_i;
                  dz    <= (bus.b_i == '0);
                  cnt   <= CW'(W);
`ifdef DIV_ZERO_FAST_EN
                  state <= (bus.b_i == '0) ? ZERO : BUSY;
`else
                  state <= BUSY;
`endif
               end
            end
            BUSY: begin
               if (bus.annul_i) begin
                  state <= IDLE;
               end else begin
                  rem <= nrem;
                  quo <= nquo;
                  cnt <= cnt - CW'(1);
                  // Results are registered on the last iteration so they line up with ready.
                  if (cnt == CW'(1)) begin
                     state <= DONE;
                     hi    <= res_hi;
                     lo    <= res_lo;
                     ready <= 1'b1;
                  end
               end
            end
`ifdef DIV_ZERO_FAST_EN
            ZERO: begin
               if (bus.annul_i) begin
                  state <= IDLE;
               end else begin
                  state <= DONE;
                  hi    <= res_hi;
                  lo    <= res_lo;
                  ready <= 1'b1;
               end
            end
`endif
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.hi_o    = hi;
   assign bus.lo_o    = lo;
   assign bus.ready_o = ready;
`ifdef DIV_ZERO_FAST_EN
   assign bus.stall_o = ((state == IDLE) && bus.start_i && !bus.annul_i) ||
                        (state == BUSY) || (state == ZERO);
`else
   assign bus.stall_o = ((state == IDLE) && bus.start_i && !bus.annul_i) ||
                        (state == BUSY);
`endif
endmodule
